// File: rtl/sevenseg_capture_if.sv
// Bus between the multiplexed seven-segment driver (master) and the
// capture monitor (slave): raw display lines in, decoded digits and status out.
interface sevenseg_capture_if;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       err_clr;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic       valid;
    logic       frame;
    logic       err;
    logic       stale;

    modport master (
        output seg, dp, an, err_clr,
        input  digit0, digit1, digit2, digit3, valid, frame, err, stale
    );

    modport slave (
        input  seg, dp, an, err_clr,
        output digit0, digit1, digit2, digit3, valid, frame, err, stale
    );
endinterface

// File: rtl/sevenseg_capture.sv
// Receive-side monitor for the four-digit seven-segment bus: waits for each
// anode window to settle, decodes the digit and tracks frame/stale/error status.
module sevenseg_capture #(
    parameter int unsigned SETTLE = 16,
    parameter int unsigned WD_W   = 21
) (
    input  logic              clock,
    input  logic              reset,
    sevenseg_capture_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_HOLD
    } state_t;

    localparam logic [WD_W-1:0] WD_MAX = '1;
    localparam logic [7:0]      CNT_LAST = 8'(SETTLE - 1);

    logic [6:0]      r_seg_meta;
    logic [6:0]      r_seg_sync;
    logic [3:0]      r_an_meta;
    logic [3:0]      r_an_sync;
    logic            r_dp_meta;
    logic            r_dp_unused;

    state_t          r_state;
    logic [7:0]      r_cnt;
    logic [6:0]      r_ref_seg;
    logic [3:0]      r_ref_an;
    logic [3:0]      r_mask;
    logic [WD_W-1:0] r_wd;
    logic [3:0]      r_digit [4];
    logic            r_valid;
    logic            r_frame;
    logic            r_err;
    logic            r_stale;

    logic            w_an_legal;
    logic            w_an_illegal;
    logic            w_changed;
    logic            w_latch;
    logic            w_capture;
    logic            w_wd_sat_next;
    logic            w_known;
    logic [3:0]      w_code;
    logic [1:0]      w_idx;
    logic [3:0]      w_mask_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_seg_meta  <= '1;
            r_seg_sync  <= '1;
            r_an_meta   <= '1;
            r_an_sync   <= '1;
            r_dp_meta   <= 1'b1;
            r_dp_unused <= 1'b1;
        end else begin
            r_seg_meta  <= bus.seg;
            r_seg_sync  <= r_seg_meta;
            r_an_meta   <= bus.an;
            r_an_sync   <= r_an_meta;
            r_dp_meta   <= bus.dp;
            r_dp_unused <= r_dp_meta;
        end
    end

    assign w_an_legal   = (r_an_sync == 4'b1110) || (r_an_sync == 4'b1101) ||
                          (r_an_sync == 4'b1011) || (r_an_sync == 4'b0111);
    assign w_an_illegal = ($countones(~r_an_sync) > 1);
    assign w_changed    = (r_an_sync != r_ref_an) || (r_seg_sync != r_ref_seg);

    // A change during SETTLE is re-evaluated as if in IDLE in the same cycle.
    assign w_latch   = w_an_legal && ((r_state == S_IDLE) || ((r_state == S_SETTLE) && w_changed));
    assign w_capture = (r_state == S_SETTLE) && !w_changed && (r_cnt == CNT_LAST);

    assign w_wd_sat_next = (r_wd == WD_MAX) || (r_wd == WD_MAX - 1'b1);
    assign w_mask_next   = r_mask | (4'b0001 << w_idx);

    always_comb begin
        w_code  = 4'hF;
        w_known = 1'b1;
        case (r_seg_sync)
            7'h40:   w_code = 4'd0;
            7'h79:   w_code = 4'd1;
            7'h24:   w_code = 4'd2;
            7'h30:   w_code = 4'd3;
            7'h19:   w_code = 4'd4;
            7'h12:   w_code = 4'd5;
            7'h02:   w_code = 4'd6;
            7'h78:   w_code = 4'd7;
            7'h00:   w_code = 4'd8;
            7'h10:   w_code = 4'd9;
            7'h3F:   w_code = 4'd10;
            default: w_known = 1'b0;
        endcase
    end

    always_comb begin
        w_idx = 2'd0;
        case (r_ref_an)
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ref_seg <= '1;
            r_ref_an  <= '1;
            r_mask    <= '0;
            r_wd      <= '0;
            r_valid   <= 1'b0;
            r_frame   <= 1'b0;
            r_err     <= 1'b0;
            r_stale   <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_digit[i] <= '0;
            end
        end else begin
            r_frame <= 1'b0;

            if (w_latch) begin
                r_state   <= S_SETTLE;
                r_cnt     <= '0;
                r_ref_an  <= r_an_sync;
                r_ref_seg <= r_seg_sync;
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_IDLE;
                    S_SETTLE: begin
                        if (w_changed) begin
                            r_state <= S_IDLE;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    S_HOLD: begin
                        if (w_changed) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end

            if (w_an_illegal) begin
                r_state <= S_IDLE;
            end

            // Clear first so a same-cycle error source keeps err set.
            if (bus.err_clr) begin
                r_err <= 1'b0;
            end
            if (w_an_illegal || (w_latch && !w_known)) begin
                r_err <= 1'b1;
            end

            if (w_capture) begin
                r_digit[w_idx] <= w_code;
                r_wd           <= '0;
                r_stale        <= 1'b0;
                if (w_mask_next == 4'hF) begin
                    r_mask  <= '0;
                    r_frame <= 1'b1;
                    r_valid <= 1'b1;
                end else begin
                    r_mask <= w_mask_next;
                end
            end else if (w_wd_sat_next) begin
                r_wd    <= WD_MAX;
                r_stale <= 1'b1;
                r_valid <= 1'b0;
                r_mask  <= '0;
            end else begin
                r_wd <= r_wd + 1'b1;
            end
        end
    end

    assign bus.digit0 = r_digit[0];
    assign bus.digit1 = r_digit[1];
    assign bus.digit2 = r_digit[2];
    assign bus.digit3 = r_digit[3];
    assign bus.valid  = r_valid;
    assign bus.frame  = r_frame;
    assign bus.err    = r_err;
    assign bus.stale  = r_stale;
endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed and randomized checks of sevenseg_capture against a window-level
// model of the display bus (digits, seen mask, frame, valid, err, stale).
module tb_sevenseg_capture;
    localparam int SETTLE = 16;
    localparam int WD_W   = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    sevenseg_capture_if bus();

    sevenseg_capture #(.SETTLE(SETTLE), .WD_W(WD_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    logic [6:0] pat_tbl [0:10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                   7'h02, 7'h78, 7'h00, 7'h10, 7'h3F};

    int         n_cmp = 0;
    int         n_fail = 0;
    int         n_frames = 0;

    logic [3:0] m_digit [4];
    logic [3:0] m_mask;
    logic       m_valid;
    logic       m_err;
    logic       m_stale;
    int         m_frames;

    always @(negedge clock) begin
        if (bus.frame === 1'b1) n_frames++;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_decode(input logic [6:0] seg);
        for (int i = 0; i < 11; i++) begin
            if (seg == pat_tbl[i]) return 4'(i);
        end
        return 4'hF;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_digit[i] = 4'h0;
        m_mask  = 4'h0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_stale = 1'b0;
    endfunction

    // One anode window of a given length, followed by a blank gap.
    function automatic void model_window(input logic [3:0] an, input logic [6:0] seg, input int dur);
        int lows;
        int idx;
        logic [3:0] code;
        lows = 0;
        idx  = 0;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) begin
                lows++;
                idx = i;
            end
        end
        if (lows >= 2) begin
            m_err = 1'b1;
            return;
        end
        if (lows == 0) return;
        code = ref_decode(seg);
        if (code == 4'hF) m_err = 1'b1;
        if (dur >= SETTLE + 4) begin
            m_digit[idx] = code;
            m_stale      = 1'b0;
            m_mask[idx]  = 1'b1;
            if (m_mask == 4'hF) begin
                m_frames++;
                m_valid = 1'b1;
                m_mask  = 4'h0;
            end
        end
    endfunction

    task automatic apply_window(input logic [3:0] an, input logic [6:0] seg, input int dur);
        bus.an  = an;
        bus.seg = seg;
        bus.dp  = 1'($urandom_range(0, 1));
        step(dur);
        bus.an  = 4'hF;
        bus.seg = 7'h7F;
        step(3);
        model_window(an, seg, dur);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_d0"},    32'(bus.digit0), 32'(m_digit[0]));
        check({tag, "_d1"},    32'(bus.digit1), 32'(m_digit[1]));
        check({tag, "_d2"},    32'(bus.digit2), 32'(m_digit[2]));
        check({tag, "_d3"},    32'(bus.digit3), 32'(m_digit[3]));
        check({tag, "_valid"}, 32'(bus.valid),  32'(m_valid));
        check({tag, "_err"},   32'(bus.err),    32'(m_err));
        check({tag, "_stale"}, 32'(bus.stale),  32'(m_stale));
        check({tag, "_frames"}, 32'(n_frames),  32'(m_frames));
    endtask

    task automatic pulse_clr();
        bus.err_clr = 1'b1;
        step(1);
        bus.err_clr = 1'b0;
        step(1);
    endtask

    initial begin
        int         pos;
        int         dur;
        int         no_cap;
        logic [3:0] an;
        logic [6:0] seg;
        logic       saw_one;

        bus.an      = 4'hF;
        bus.seg     = 7'h7F;
        bus.dp      = 1'b1;
        bus.err_clr = 1'b0;
        m_frames    = 0;
        model_reset();

        step(3);
        check_all("reset");
        check("reset_frame", 32'(bus.frame), 32'd0);
        reset = 1'b0;
        step(2);

        // Basic scan of codes 1..4 across all four digits.
        apply_window(4'b1110, 7'h79, 100);
        apply_window(4'b1101, 7'h24, 100);
        apply_window(4'b1011, 7'h30, 100);
        apply_window(4'b0111, 7'h19, 100);
        check_all("scan");

        // Segment glitching inside a digit-0 window.
        apply_window(4'b1110, 7'h00, 40);
        check_all("pre_glitch");
        saw_one = 1'b0;
        bus.an  = 4'b1110;
        for (int k = 0; k < 8; k++) begin
            bus.seg = (k % 2 == 0) ? 7'h79 : 7'h24;
            for (int c = 0; c < 5; c++) begin
                step(1);
                if (bus.digit0 === 4'd1) saw_one = 1'b1;
            end
        end
        for (int c = 0; c < 40; c++) begin
            step(1);
            if (bus.digit0 === 4'd1) saw_one = 1'b1;
        end
        bus.an  = 4'hF;
        bus.seg = 7'h7F;
        step(3);
        model_window(4'b1110, 7'h24, 40);
        check("glitch_no_one", 32'(saw_one), 32'd0);
        check_all("glitch");

        // Unknown pattern, err_clr, and err_clr racing an illegal anode.
        apply_window(4'b1110, 7'h7F, 40);
        check_all("unknown");
        pulse_clr();
        m_err = 1'b0;
        check("clr_err", 32'(bus.err), 32'(m_err));
        bus.an  = 4'b1100;
        bus.seg = 7'h40;
        step(4);
        pulse_clr();
        model_window(4'b1100, 7'h40, 6);
        check("clr_vs_illegal", 32'(bus.err), 32'(m_err));
        bus.an  = 4'hF;
        bus.seg = 7'h7F;
        step(3);
        pulse_clr();
        m_err = 1'b0;
        check_all("post_illegal");

        // Watchdog: finish a frame, then go blank long enough to saturate.
        apply_window(4'b1101, 7'h12, 40);
        apply_window(4'b1011, 7'h02, 40);
        apply_window(4'b0111, 7'h78, 40);
        check_all("pre_stale");
        step(200);
        check("stale_early", 32'(bus.stale), 32'd0);
        step(80);
        m_stale = 1'b1;
        m_valid = 1'b0;
        m_mask  = 4'h0;
        check_all("stale");
        apply_window(4'b1011, 7'h30, 40);
        check_all("stale_cleared");
        apply_window(4'b1110, 7'h10, 40);
        apply_window(4'b1101, 7'h3F, 40);
        check_all("stale_partial");
        apply_window(4'b0111, 7'h40, 40);
        check_all("stale_refill");

        // Duplicate digit 3 must not count twice toward a frame.
        apply_window(4'b0111, 7'h12, 40);
        apply_window(4'b0111, 7'h78, 40);
        apply_window(4'b1110, 7'h79, 40);
        apply_window(4'b1101, 7'h24, 40);
        check_all("dup_partial");
        apply_window(4'b1011, 7'h30, 40);
        check_all("dup_frame");

        // Asynchronous reset while digit 2 is settling.
        bus.an  = 4'b1011;
        bus.seg = 7'h02;
        step(10);
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        check("async_reset_frame", 32'(bus.frame), 32'd0);
        bus.an  = 4'hF;
        bus.seg = 7'h7F;
        step(3);
        reset = 1'b0;
        step(20);
        check_all("post_reset");
        apply_window(4'b1011, 7'h02, 40);
        check_all("resume");

        // Randomized windows, occasionally short or carrying unknown patterns.
        no_cap = 0;
        for (int w = 0; w < 40; w++) begin
            pos = $urandom_range(0, 3);
            an  = ~(4'b0001 << pos);
            if ($urandom_range(0, 7) == 0) seg = 7'($urandom_range(0, 127));
            else                            seg = pat_tbl[$urandom_range(0, 10)];
            if (no_cap < 4 && $urandom_range(0, 5) == 0) begin
                dur = $urandom_range(3, 12);
                no_cap++;
            end else begin
                dur = $urandom_range(20, 60);
                no_cap = 0;
            end
            apply_window(an, seg, dur);
            if ($urandom_range(0, 9) == 0) begin
                pulse_clr();
                m_err = 1'b0;
            end
            check_all($sformatf("rnd%0d", w));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
